// File: rtl/ad9866_spi_slave.sv
// AD9866 4-wire serial-port responder: decodes 16-bit frames into a shadow
// register file and serves read-back on SDO plus a parallel read port.
module ad9866_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NREGS       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_sen_n,
    input  logic       spi_sdio,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    output logic       reg_we,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_err,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DONE} state_t;

    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic w_sclk, w_sen_n, w_sdio;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_sclk  = spi_sclk;
        assign w_sen_n = spi_sen_n;
        assign w_sdio  = spi_sdio;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sclk_s, r_sen_s, r_sdio_s;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sclk_s <= '0;
                r_sen_s  <= '1;
                r_sdio_s <= '0;
            end else begin
                r_sclk_s[0] <= spi_sclk;
                r_sen_s[0]  <= spi_sen_n;
                r_sdio_s[0] <= spi_sdio;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    r_sclk_s[i] <= r_sclk_s[i-1];
                    r_sen_s[i]  <= r_sen_s[i-1];
                    r_sdio_s[i] <= r_sdio_s[i-1];
                end
            end
        end

        assign w_sclk  = r_sclk_s[SYNC_STAGES-1];
        assign w_sen_n = r_sen_s[SYNC_STAGES-1];
        assign w_sdio  = r_sdio_s[SYNC_STAGES-1];
    end

    // Edge flags are registered so sclk and sen_n events stay cycle-aligned
    // with the sdio sample taken alongside them.
    logic r_sclk_d, r_sen_d, r_rise, r_fall, r_sen_rise, r_sen_fall, r_sdio_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_d   <= 1'b0;
            r_sen_d    <= 1'b1;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_sen_rise <= 1'b0;
            r_sen_fall <= 1'b0;
            r_sdio_q   <= 1'b0;
        end else begin
            r_sclk_d   <= w_sclk;
            r_sen_d    <= w_sen_n;
            r_rise     <= w_sclk & ~r_sclk_d;
            r_fall     <= ~w_sclk & r_sclk_d;
            r_sen_rise <= w_sen_n & ~r_sen_d;
            r_sen_fall <= ~w_sen_n & r_sen_d;
            r_sdio_q   <= w_sdio;
        end
    end

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic [6:0]  r_sr;
    logic        r_rw;
    logic [4:0]  r_addr;
    logic [7:0]  r_obuf;
    logic        r_wr_pend;
    logic [4:0]  r_wa;
    logic [7:0]  r_wd;
    logic [7:0]  r_shadow [NREGS];

    logic        w_shift, w_hdr_done, w_last, w_err, w_exit;
    logic [7:0]  w_byte, w_rdval;

    assign w_byte = {r_sr, r_sdio_q};
    assign w_exit = (w_state_nxt == S_IDLE) && (r_state != S_IDLE);

    always_comb begin
        w_rdval = '0;
        if ({1'b0, w_byte[4:0]} < NREGS_W)
            w_rdval = r_shadow[w_byte[4:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_hdr_done  = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sen_fall) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                if (r_sen_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_rise) begin
                    w_shift = 1'b1;
                    if (r_cnt == 4'd7) begin
                        w_hdr_done  = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // A final bit arriving with sen_n release still completes the frame.
                if (r_rise && r_cnt == 4'd15) begin
                    w_shift     = 1'b1;
                    w_last      = 1'b1;
                    w_state_nxt = r_sen_rise ? S_IDLE : S_DONE;
                end else if (r_sen_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_rise) begin
                    w_shift = 1'b1;
                end
            end
            S_DONE: begin
                if (r_sen_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_sr       <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_obuf     <= '0;
            r_wr_pend  <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= w_err;
            r_wr_pend <= w_last & ~r_rw;
            reg_we    <= r_wr_pend;

            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + 4'd1;
                r_sr  <= w_byte[6:0];
            end

            if (w_hdr_done) begin
                r_rw   <= w_byte[7];
                r_addr <= w_byte[4:0];
            end

            if (w_last && !r_rw) begin
                r_wa <= r_addr;
                r_wd <= w_byte;
            end

            if (r_wr_pend) begin
                reg_addr  <= r_wa;
                reg_wdata <= r_wd;
            end

            // The MSB stays on SDO until the first data bit has been clocked in.
            if (w_exit) begin
                spi_sdo    <= 1'b0;
                spi_sdo_oe <= 1'b0;
            end else if (w_hdr_done && w_byte[7]) begin
                r_obuf     <= w_rdval;
                spi_sdo    <= w_rdval[7];
                spi_sdo_oe <= 1'b1;
            end else if (r_state == S_DATA && r_rw && r_fall && r_cnt != 4'd8) begin
                spi_sdo <= r_obuf[6];
                r_obuf  <= {r_obuf[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) r_shadow[i] <= '0;
        end else if (r_wr_pend && ({1'b0, r_wa} < NREGS_W)) begin
            r_shadow[r_wa] <= r_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              rd_data <= '0;
        else if ({1'b0, rd_addr} < NREGS_W)    rd_data <= r_shadow[rd_addr];
        else                                   rd_data <= '0;
    end

endmodule

// File: tb/tb_ad9866_spi_slave.sv
// Directed bench for ad9866_spi_slave: write/read frames, out-of-range
// addresses, short frames, trailing clocks and mid-frame reset.
module tb_ad9866_spi_slave;

    localparam int SYNC = 2;

    logic       clk, rst;
    logic       spi_sclk, spi_sen_n, spi_sdio;
    logic       spi_sdo, spi_sdo_oe;
    logic       reg_we, frame_err;
    logic [4:0] reg_addr, rd_addr;
    logic [7:0] reg_wdata, rd_data;

    ad9866_spi_slave #(.SYNC_STAGES(SYNC), .NREGS(20)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_sen_n(spi_sen_n), .spi_sdio(spi_sdio),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .frame_err(frame_err), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, c16 = 0, we_cyc = 0;
    int we_cnt = 0, err_cnt = 0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (reg_we) begin
                we_cnt    = we_cnt + 1;
                last_addr = reg_addr;
                last_data = reg_wdata;
                we_cyc    = cyc;
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame(input logic [15:0] f, input int nbits, input int extra,
                         input int hi, input int lo,
                         output logic [7:0] sdo_b, output logic [7:0] oe_b);
        sdo_b = '0;
        oe_b  = '0;
        @(negedge clk);
        spi_sen_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits + extra; i++) begin
            spi_sclk = 1'b0;
            spi_sdio = (i < 16) ? f[15-i] : 1'b1;
            repeat (lo) @(negedge clk);
            if (i >= 8 && i < 16) begin
                sdo_b[15-i] = spi_sdo;
                oe_b[15-i]  = spi_sdo_oe;
            end
            if (i == 15) c16 = cyc;
            spi_sclk = 1'b1;
            repeat (hi) @(negedge clk);
        end
        spi_sclk = 1'b0;
        repeat (lo) @(negedge clk);
        spi_sen_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        repeat (2) @(negedge clk);
        d = rd_data;
    endtask

    logic [7:0] sb, ob, v, acc;
    int we0, er0;

    initial begin
        rst = 1'b0; spi_sclk = 1'b0; spi_sen_n = 1'b1; spi_sdio = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {spi_sdo, spi_sdo_oe, reg_we, frame_err, reg_addr, reg_wdata, rd_data}, '0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0x0A43 at the fastest sclk
        frame(16'h0A43, 16, 0, 1, 1, sb, ob);
        chk("w1_we_cnt", we_cnt, 1);
        chk("w1_addr", last_addr, 5'h0A);
        chk("w1_data", last_data, 8'h43);
        chk("w1_latency", we_cyc - c16, SYNC + 3);
        chk("w1_no_err", err_cnt, 0);
        rd(5'h0A, v);
        chk("w1_rd_data", v, 8'h43);

        // Write 0x0C43 then read it back over SDO
        frame(16'h0C43, 16, 0, 1, 1, sb, ob);
        chk("w2_we_cnt", we_cnt, 2);
        frame(16'h8C00, 16, 0, 4, 4, sb, ob);
        chk("r2_sdo_byte", sb, 8'h43);
        chk("r2_oe_byte", ob, 8'hFF);
        chk("r2_no_we", we_cnt, 2);
        chk("r2_oe_after", {spi_sdo_oe, spi_sdo}, 2'b00);

        // Out-of-range address
        frame(16'h1555, 16, 0, 1, 1, sb, ob);
        chk("w3_we_cnt", we_cnt, 3);
        chk("w3_addr", last_addr, 5'h15);
        chk("w3_data", last_data, 8'h55);
        frame(16'h9500, 16, 0, 4, 4, sb, ob);
        chk("r3_sdo_byte", sb, 8'h00);
        chk("r3_oe_byte", ob, 8'hFF);
        rd(5'h15, v);
        chk("r3_rd_data", v, 8'h00);

        // Short frame, then a good write
        frame(16'h0B20, 11, 0, 1, 1, sb, ob);
        chk("s4_err_cnt", err_cnt, 1);
        chk("s4_no_we", we_cnt, 3);
        rd(5'h0B, v);
        chk("s4_reg_untouched", v, 8'h00);
        frame(16'h0B20, 16, 0, 1, 1, sb, ob);
        chk("w4_we_cnt", we_cnt, 4);
        chk("w4_addr", last_addr, 5'h0B);
        chk("w4_data", last_data, 8'h20);
        chk("w4_err_cnt", err_cnt, 1);
        rd(5'h0B, v);
        chk("w4_rd_data", v, 8'h20);

        // Trailing sclk pulses after bit 16
        frame(16'h0E5A, 16, 20, 1, 1, sb, ob);
        chk("x5_we_cnt", we_cnt, 5);
        chk("x5_data", last_data, 8'h5A);
        chk("x5_err_cnt", err_cnt, 1);
        rd(5'h0E, v);
        chk("x5_rd_data", v, 8'h5A);

        // Reset mid-frame after 6 bits
        we0 = we_cnt;
        er0 = err_cnt;
        @(negedge clk);
        spi_sen_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            spi_sclk = 1'b0;
            spi_sdio = i[0];
            @(negedge clk);
            spi_sclk = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        spi_sclk = 1'b0;
        spi_sen_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        acc = '0;
        for (int a = 0; a < 20; a++) begin
            rd(5'(a), v);
            acc = acc | v;
        end
        chk("r6_all_zero", acc, 8'h00);
        chk("r6_no_err", err_cnt, er0);
        chk("r6_no_we", we_cnt, we0);
        frame(16'h0754, 16, 0, 1, 1, sb, ob);
        chk("w6_we_cnt", we_cnt, we0 + 1);
        acc = '0;
        for (int a = 0; a < 20; a++) begin
            rd(5'(a), v);
            if (a == 7) chk("w6_reg07", v, 8'h54);
            else acc = acc | v;
        end
        chk("w6_others_zero", acc, 8'h00);
        chk("w6_no_err", err_cnt, er0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
